arb_grant_sink: RTL and testbench

Downstream consumer of the 8-requester arbiter's one-hot grant vector. Each cycle the arbiter grants a requester, the block captures that requester's data word and index into a small FIFO and presents them on a valid/ready output port. It also flags illegal (multi-hot) grants and counts grants it had to drop because the FIFO was full. It sits between the arbiter and the shared resource the arbiter protects.

---
 rtl/arb_grant_sink.sv | 127 ++++++++++++
 tb/tb_arb_grant_sink.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/arb_grant_sink.sv
// Grant sink: captures the one-hot granted requester's {data, index} into a FIFO.
// Optional per-requester grant statistics are built when ARB_GRANT_STATS_EN is defined.
module arb_grant_sink #(
   parameter int DW    = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       grant_in,
   input  logic [8*DW-1:0]  data_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DW-1:0]    out_data,
   output logic [2:0]       out_id,
   output logic             full,
   output logic             err_multi,
   output logic [CNT_W-1:0] drop_cnt,
   input  logic [2:0]       stat_sel,
   output logic [CNT_W-1:0] stat_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {OCC_EMPTY, OCC_PARTIAL, OCC_FULL} occ_e;

   occ_e               occ_q, occ_d;
   logic [CW-1:0]      count_q, count_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [DW+2:0]      mem_q [DEPTH];
   logic [DW+2:0]      mem_d [DEPTH];
   logic               err_multi_q, err_multi_d;
   logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

   logic               one_hot, multi_hot, pop, push, drop;
   logic [DW-1:0]      sel_data;
   logic [2:0]         sel_id;

   always_comb begin
      sel_data = '0;
      sel_id   = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (grant_in[i]) begin
            sel_data = data_in[i*DW +: DW];
            sel_id   = 3'(i);
         end
      end
      one_hot   = (grant_in != '0) && ((grant_in & (grant_in - 8'd1)) == '0);
      multi_hot = (grant_in != '0) && !one_hot;
      pop       = (occ_q != OCC_EMPTY) && out_ready;
      // A full FIFO still accepts when the head leaves in the same cycle
      push      = one_hot && ((count_q != DEPTH_C) || pop);
      drop      = one_hot && !push;

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = {sel_data, sel_id};
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);

      if (count_d == '0)          occ_d = OCC_EMPTY;
      else if (count_d == DEPTH_C) occ_d = OCC_FULL;
      else                        occ_d = OCC_PARTIAL;

      err_multi_d = err_multi_q | multi_hot;
      drop_cnt_d  = drop_cnt_q;
      if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q       <= OCC_EMPTY;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         mem_q       <= '{default: '0};
         err_multi_q <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         occ_q       <= occ_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         mem_q       <= mem_d;
         err_multi_q <= err_multi_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign out_valid = (occ_q != OCC_EMPTY);
   assign full      = (occ_q == OCC_FULL);
   assign out_data  = mem_q[rd_ptr_q][DW+2:3];
   assign out_id    = mem_q[rd_ptr_q][2:0];
   assign err_multi = err_multi_q;
   assign drop_cnt  = drop_cnt_q;

`ifdef ARB_GRANT_STATS_EN
   logic [CNT_W-1:0] stat_q [8];
   logic [CNT_W-1:0] stat_d [8];

   always_comb begin
      stat_d = stat_q;
      if (push && (stat_q[sel_id] != '1)) stat_d[sel_id] = stat_q[sel_id] + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stat_q <= '{default: '0};
      else        stat_q <= stat_d;
   end

   assign stat_cnt = stat_q[stat_sel];
`else
   logic stat_sel_unused;
   assign stat_sel_unused = ^stat_sel;
   assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_arb_grant_sink.sv
// Directed bench for arb_grant_sink: vector table plus reset and statistics sequences.
module tb_arb_grant_sink;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  grant_in;
   logic [63:0] data_in;
   logic        out_valid, out_ready, full, err_multi;
   logic [7:0]  out_data;
   logic [2:0]  out_id, stat_sel;
   logic [15:0] drop_cnt, stat_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   arb_grant_sink #(.DW(8), .DEPTH(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .grant_in(grant_in), .data_in(data_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_id(out_id), .full(full), .err_multi(err_multi), .drop_cnt(drop_cnt),
      .stat_sel(stat_sel), .stat_cnt(stat_cnt)
   );

   typedef struct {
      logic [7:0]  grant;
      logic [7:0]  base;
      logic        rdy;
      logic        ev;
      logic [7:0]  ed;
      logic [2:0]  eid;
      logic        ef;
      logic        ee;
      logic [15:0] edrop;
   } vec_t;

   vec_t vecs[23];

   function automatic logic [63:0] words(input logic [7:0] base);
      logic [63:0] w;
      for (int i = 0; i < 8; i++) w[i*8 +: 8] = base + 8'(i);
      return w;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      //            grant  base  rdy ev  data   id  full err drop
      vecs[0]  = '{8'h02, 8'hA4, 1, 1, 8'hA5, 3'd1, 0, 0, 16'd0};
      vecs[1]  = '{8'h00, 8'h00, 1, 0, 8'h00, 3'd0, 0, 0, 16'd0};
      vecs[2]  = '{8'h01, 8'h10, 0, 1, 8'h10, 3'd0, 0, 0, 16'd0};
      vecs[3]  = '{8'h02, 8'h10, 0, 1, 8'h10, 3'd0, 0, 0, 16'd0};
      vecs[4]  = '{8'h04, 8'h10, 0, 1, 8'h10, 3'd0, 0, 0, 16'd0};
      vecs[5]  = '{8'h08, 8'h10, 0, 1, 8'h10, 3'd0, 1, 0, 16'd0};
      vecs[6]  = '{8'h10, 8'h10, 0, 1, 8'h10, 3'd0, 1, 0, 16'd1};
      vecs[7]  = '{8'h00, 8'h00, 1, 1, 8'h11, 3'd1, 0, 0, 16'd1};
      vecs[8]  = '{8'h00, 8'h00, 1, 1, 8'h12, 3'd2, 0, 0, 16'd1};
      vecs[9]  = '{8'h00, 8'h00, 1, 1, 8'h13, 3'd3, 0, 0, 16'd1};
      vecs[10] = '{8'h00, 8'h00, 1, 0, 8'h00, 3'd0, 0, 0, 16'd1};
      vecs[11] = '{8'h01, 8'h20, 0, 1, 8'h20, 3'd0, 0, 0, 16'd1};
      vecs[12] = '{8'h02, 8'h20, 0, 1, 8'h20, 3'd0, 0, 0, 16'd1};
      vecs[13] = '{8'h04, 8'h20, 0, 1, 8'h20, 3'd0, 0, 0, 16'd1};
      vecs[14] = '{8'h08, 8'h20, 0, 1, 8'h20, 3'd0, 1, 0, 16'd1};
      vecs[15] = '{8'h80, 8'h20, 1, 1, 8'h21, 3'd1, 1, 0, 16'd1};
      vecs[16] = '{8'h00, 8'h00, 1, 1, 8'h22, 3'd2, 0, 0, 16'd1};
      vecs[17] = '{8'h00, 8'h00, 1, 1, 8'h23, 3'd3, 0, 0, 16'd1};
      vecs[18] = '{8'h00, 8'h00, 1, 1, 8'h27, 3'd7, 0, 0, 16'd1};
      vecs[19] = '{8'h00, 8'h00, 1, 0, 8'h00, 3'd0, 0, 0, 16'd1};
      vecs[20] = '{8'h41, 8'h30, 1, 0, 8'h00, 3'd0, 0, 1, 16'd1};
      vecs[21] = '{8'h04, 8'h30, 0, 1, 8'h32, 3'd2, 0, 1, 16'd1};
      vecs[22] = '{8'h00, 8'h00, 1, 0, 8'h00, 3'd0, 0, 1, 16'd1};

      rst_n = 1'b0; grant_in = '0; data_in = '0; out_ready = 1'b0; stat_sel = 3'd6;
      #3;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_id", out_id, 0);
      chk("rst_full", full, 0);
      chk("rst_err", err_multi, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_stat", stat_cnt, 0);
      #4 rst_n = 1'b1;

      for (int v = 0; v < 23; v++) begin
         grant_in  = vecs[v].grant;
         data_in   = words(vecs[v].base);
         out_ready = vecs[v].rdy;
         step();
         chk($sformatf("v%0d_valid", v), out_valid, vecs[v].ev);
         if (vecs[v].ev) begin
            chk($sformatf("v%0d_data", v), out_data, vecs[v].ed);
            chk($sformatf("v%0d_id", v), out_id, vecs[v].eid);
         end
         chk($sformatf("v%0d_full", v), full, vecs[v].ef);
         chk($sformatf("v%0d_err", v), err_multi, vecs[v].ee);
         chk($sformatf("v%0d_drop", v), drop_cnt, vecs[v].edrop);
      end

      // Async reset between edges with three entries queued
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         grant_in = 8'h01 << i;
         data_in  = words(8'h50);
         step();
      end
      grant_in = '0;
      chk("pre_rst_valid", out_valid, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_full", full, 0);
      chk("mid_rst_drop", drop_cnt, 0);
      chk("mid_rst_err", err_multi, 0);
      chk("mid_rst_data", out_data, 0);
      #2 rst_n = 1'b1;
      grant_in = 8'h02; data_in = words(8'h60);
      step();
      chk("post_rst_valid", out_valid, 1);
      chk("post_rst_id", out_id, 1);
      chk("post_rst_data", out_data, 8'h61);
      grant_in = '0; out_ready = 1'b1;
      step();
      chk("post_rst_empty", out_valid, 0);

      // Statistics: three accepted and one dropped grant for requester 6
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         grant_in = 8'h40; data_in = words(8'h70);
         step();
      end
      grant_in = 8'h01;
      step();
      chk("st_full", full, 1);
      grant_in = 8'h40;
      step();
      grant_in = '0;
      chk("st_drop", drop_cnt, 1);
      stat_sel = 3'd6;
      #1;
`ifdef ARB_GRANT_STATS_EN
      chk("stat6", stat_cnt, 3);
      stat_sel = 3'd0; #1;
      chk("stat0", stat_cnt, 1);
      stat_sel = 3'd1; #1;
      chk("stat1", stat_cnt, 1);
`else
      chk("stat6", stat_cnt, 0);
      stat_sel = 3'd0; #1;
      chk("stat0", stat_cnt, 0);
`endif
      out_ready = 1'b1;
      step();
      chk("st_head_id", out_id, 6);
      chk("st_head_data", out_data, 8'h76);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
